dcache_2way: RTL and testbench

- Parametrised 2-way set-associative, write-back, write-allocate data cache with per-set LRU replacement.
- Sits between the CPU datapath (byte load/store port with busywait stall) and the block-wide data memory.
- Successor to the direct-mapped 8-line cache: configurable address width, set count and block size, plus two ways and saturating hit/miss counters.

---
 rtl/dcache_pkg.sv | 39 +++
 rtl/dcache_way.sv | 64 ++++++
 rtl/dcache_2way.sv | 151 +++++++++++++++
 tb/tb_dcache_2way.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the 2-way set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  localparam int WAYS = 2;

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int calc_block_w(input int data_w, input int offset_w);
    return data_w << offset_w;
  endfunction

  function automatic int calc_sets(input int index_w);
    return 1 << index_w;
  endfunction

  function automatic logic [31:0] field_mask(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Field extractors work on a zero-extended address; callers size-cast the result.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offset_w);
    return addr & field_mask(offset_w);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int offset_w,
                                             input int index_w);
    return (addr >> offset_w) & field_mask(index_w);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int offset_w,
                                           input int index_w, input int tag_w);
    return (addr >> (offset_w + index_w)) & field_mask(tag_w);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: per-set tag/valid/dirty/data storage with combinational lookup.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [INDEX_W-1:0]                    index,
  input  logic [OFFSET_W-1:0]                   offset,
  input  logic [TAG_W-1:0]                      tag,
  input  logic                                  word_we,
  input  logic [DATA_W-1:0]                     word_data,
  input  logic                                  fill_en,
  input  logic [calc_block_w(DATA_W, OFFSET_W)-1:0] fill_line,
  output logic                                  hit,
  output logic                                  valid,
  output logic                                  dirty,
  output logic [TAG_W-1:0]                      line_tag,
  output logic [DATA_W-1:0]                     word,
  output logic [calc_block_w(DATA_W, OFFSET_W)-1:0] line
);

  localparam int BLOCK_W = calc_block_w(DATA_W, OFFSET_W);
  localparam int SETS    = calc_sets(INDEX_W);

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tags and data are not reset: valid gates every use of them.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[index]  <= tag;
      data_q[index] <= fill_line;
    end else if (word_we) begin
      data_q[index][int'(offset)*DATA_W +: DATA_W] <= word_data;
    end
  end

  assign valid    = valid_q[index];
  assign dirty    = dirty_q[index];
  assign line_tag = tag_q[index];
  assign line     = data_q[index];
  assign word     = line[int'(offset)*DATA_W +: DATA_W];
  assign hit      = valid && (tag_q[index] == tag);

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back/write-allocate data cache with per-set LRU
// replacement and saturating hit/miss counters.
module dcache_2way
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         read,
  input  logic                         write,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            writedata,
  output logic [DATA_W-1:0]            readdata,
  output logic                         busywait,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDR_W-OFFSET_W-1:0]   mem_address,
  output logic [(DATA_W<<OFFSET_W)-1:0] mem_writedata,
  input  logic [(DATA_W<<OFFSET_W)-1:0] mem_readdata,
  input  logic                         mem_busywait,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int TAG_W   = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int BLOCK_W = calc_block_w(DATA_W, OFFSET_W);
  localparam int SETS    = calc_sets(INDEX_W);

  state_t state, state_next;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                request;
  logic                hit;
  logic                hit_way;
  logic                victim_sel;
  logic                victim_q;
  logic                missed_q;
  logic [SETS-1:0]     lru_q;

  logic [WAYS-1:0]     way_hit, way_valid, way_dirty, way_we, way_fill;
  logic [TAG_W-1:0]    way_tag  [WAYS];
  logic [DATA_W-1:0]   way_word [WAYS];
  logic [BLOCK_W-1:0]  way_line [WAYS];

  assign req_tag    = TAG_W'(addr_tag(32'(address), OFFSET_W, INDEX_W, TAG_W));
  assign req_index  = INDEX_W'(addr_index(32'(address), OFFSET_W, INDEX_W));
  assign req_offset = OFFSET_W'(addr_offset(32'(address), OFFSET_W));

  assign request = read | write;
  assign hit     = |way_hit;
  assign hit_way = way_hit[1];

  // Fill an empty way first (way 0 preferred); otherwise evict the least recently used.
  assign victim_sel = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru_q[req_index];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .TAG_W    (TAG_W),
      .DATA_W   (DATA_W),
      .OFFSET_W (OFFSET_W),
      .INDEX_W  (INDEX_W)
    ) u_way (
      .clock     (clock),
      .reset     (reset),
      .index     (req_index),
      .offset    (req_offset),
      .tag       (req_tag),
      .word_we   (way_we[w]),
      .word_data (writedata),
      .fill_en   (way_fill[w]),
      .fill_line (mem_readdata),
      .hit       (way_hit[w]),
      .valid     (way_valid[w]),
      .dirty     (way_dirty[w]),
      .line_tag  (way_tag[w]),
      .word      (way_word[w]),
      .line      (way_line[w])
    );
  end

  always_comb begin
    way_we   = '0;
    way_fill = '0;
    if (state == IDLE && write) way_we = way_hit;
    if (state == FETCH && !mem_busywait && !reset) way_fill[victim_q] = 1'b1;
  end

  assign readdata = (read && hit) ? way_word[hit_way] : '0;

  always_comb begin
    state_next    = state;
    busywait      = 1'b1;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        busywait = request && !hit;
        if (request && !hit)
          state_next = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {way_tag[victim_q], req_index};
        mem_writedata = way_line[victim_q];
        if (!mem_busywait) state_next = FETCH;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = address[ADDR_W-1:OFFSET_W];
        if (!mem_busywait) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lru_q      <= '0;
      victim_q   <= 1'b0;
      missed_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && request) begin
        if (hit) begin
          lru_q[req_index] <= ~hit_way;
          missed_q         <= 1'b0;
          // The completion of a refilled request is not a fresh hit.
          if (!missed_q && hit_count != '1) hit_count <= hit_count + 1'b1;
        end else begin
          victim_q <= victim_sel;
          missed_q <= 1'b1;
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Self-checking bench for dcache_2way: vector table with a byte-level reference
// memory, a readdata scoreboard and an expected memory-transaction queue.
module tb_dcache_2way;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 2;
  localparam int CNT_W    = 4;
  localparam int MEM_LAT  = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic        clock;
  logic        reset;
  logic        read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  hit_count, miss_count;

  dcache_2way #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       miss;
    logic       wb;
    logic [5:0] wb_blk;
  } op_t;

  typedef struct {
    logic        is_wr;
    logic [5:0]  blk;
    logic [31:0] data;
  } mem_exp_t;

  op_t         ops[$];
  mem_exp_t    mem_q[$];
  logic [7:0]  rd_q[$];
  logic [31:0] mem_blk [64];
  logic [7:0]  ref_mem [256];
  int          errors = 0;
  int          checks = 0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  int          mem_cnt = 0;

  // Memory: busy from the first request cycle for MEM_LAT cycles, ready on the next.
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < MEM_LAT);
  assign mem_readdata = mem_blk[mem_address];

  always @(posedge clock) begin
    if ((mem_read || mem_write) && mem_cnt < MEM_LAT) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  function automatic logic [31:0] blk_init(input int k);
    return 32'h44332211 + 32'(k) * 32'h01010101;
  endfunction

  function automatic logic [31:0] ref_line(input logic [5:0] blk);
    return {ref_mem[{blk, 2'd3}], ref_mem[{blk, 2'd2}], ref_mem[{blk, 2'd1}], ref_mem[{blk, 2'd0}]};
  endfunction

  function automatic op_t mk(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic miss, input logic wb, input logic [5:0] wb_blk);
    op_t o;
    o.wr = wr; o.addr = addr; o.wdata = wdata; o.miss = miss; o.wb = wb; o.wb_blk = wb_blk;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called once per stalled cycle; handles a transfer the memory accepts at the next edge.
  task automatic mem_step();
    mem_exp_t e;
    if ((mem_read || mem_write) && !mem_busywait) begin
      if (mem_q.size() == 0) begin
        check("mem_unexpected", {31'd0, mem_write}, 32'hFFFF_FFFF);
      end else begin
        e = mem_q.pop_front();
        check("mem_write", 32'(mem_write), 32'(e.is_wr));
        check("mem_read", 32'(mem_read), 32'(!e.is_wr));
        check("mem_address", 32'(mem_address), 32'(e.blk));
        if (e.is_wr) begin
          check("mem_writedata", mem_writedata, e.data);
          mem_blk[mem_address] = mem_writedata;
        end
      end
    end
  endtask

  task automatic do_op(input op_t o);
    int       stalls;
    int       exp_stalls;
    mem_exp_t e;
    logic [7:0] exp_rd;
    @(negedge clock);
    read = !o.wr; write = o.wr; address = o.addr; writedata = o.wdata;
    rd_q.push_back(o.wr ? 8'h00 : ref_mem[o.addr]);
    if (o.miss) begin
      if (o.wb) begin
        e.is_wr = 1'b1; e.blk = o.wb_blk; e.data = ref_line(o.wb_blk);
        mem_q.push_back(e);
      end
      e.is_wr = 1'b0; e.blk = o.addr[7:2]; e.data = 32'h0;
      mem_q.push_back(e);
      exp_misses++;
    end else begin
      exp_hits++;
    end
    if (o.wr) ref_mem[o.addr] = o.wdata;
    exp_stalls = o.miss ? 1 + (o.wb ? 2 : 1) * (MEM_LAT + 1) : 0;
    stalls = 0;
    #1;
    while (busywait && stalls < 50) begin
      mem_step();
      @(negedge clock);
      #1;
      stalls++;
    end
    check($sformatf("stall_cycles@%h", o.addr), 32'(stalls), 32'(exp_stalls));
    exp_rd = rd_q.pop_front();
    check($sformatf("readdata@%h", o.addr), 32'(readdata), 32'(exp_rd));
    check("mem_pending", 32'(mem_q.size()), 32'd0);
    mem_q.delete();
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    logic [31:0] b;
    for (int k = 0; k < 64; k++) mem_blk[k] = blk_init(k);
    for (int a = 0; a < 256; a++) begin
      b = blk_init(a >> 2);
      ref_mem[a] = b[8*(a%4) +: 8];
    end

    // Cold start, alternating hits, LRU eviction, writeback, write-miss allocate.
    ops.push_back(mk(0, 8'h00, 8'h00, 1, 0, 6'h00));
    ops.push_back(mk(0, 8'h01, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h10, 8'h00, 1, 0, 6'h00));
    for (int i = 0; i < 8; i++) ops.push_back(mk(0, (i % 2 == 0) ? 8'h00 : 8'h10, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h00, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h10, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h00, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h20, 8'h00, 1, 0, 6'h00));
    ops.push_back(mk(0, 8'h00, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h10, 8'h00, 1, 0, 6'h00));
    ops.push_back(mk(1, 8'h00, 8'hAB, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h10, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h20, 8'h00, 1, 1, 6'h00));
    ops.push_back(mk(0, 8'h00, 8'h00, 1, 0, 6'h00));
    ops.push_back(mk(1, 8'h07, 8'h5C, 1, 0, 6'h00));
    ops.push_back(mk(0, 8'h07, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h04, 8'h00, 0, 0, 6'h00));
    ops.push_back(mk(0, 8'h17, 8'h00, 1, 0, 6'h00));
    ops.push_back(mk(0, 8'h27, 8'h00, 1, 1, 6'h01));

    reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_busywait", 32'(busywait), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_readdata", 32'(readdata), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_writedata", mem_writedata, 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_miss_count", 32'(miss_count), 32'd0);

    for (int i = 0; i < ops.size(); i++) begin
      do_op(ops[i]);
      if (i == 1) begin
        check("hit_count_cold", 32'(hit_count), 32'(exp_hits));
        check("miss_count_cold", 32'(miss_count), 32'(exp_misses));
      end
    end
    check("hit_count_sat", 32'(hit_count), 32'((exp_hits > CNT_MAX) ? CNT_MAX : exp_hits));
    check("miss_count_end", 32'(miss_count), 32'((exp_misses > CNT_MAX) ? CNT_MAX : exp_misses));

    // Reset while a fetch is outstanding: request must drop, nothing installed.
    @(negedge clock);
    read = 1'b1; address = 8'h30;
    #1;
    check("abort_req_stall", 32'(busywait), 32'd1);
    @(negedge clock);
    #1;
    check("abort_in_fetch", 32'(mem_read), 32'd1);
    check("abort_fetch_busy", 32'(mem_busywait), 32'd1);
    check("abort_fetch_addr", 32'(mem_address), 32'h0C);
    reset = 1'b1; read = 1'b0;
    @(negedge clock);
    #1;
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_busywait", 32'(busywait), 32'd0);
    check("abort_hit_count", 32'(hit_count), 32'd0);
    check("abort_miss_count", 32'(miss_count), 32'd0);
    reset = 1'b0;
    exp_hits = 0; exp_misses = 0;
    do_op(mk(0, 8'h00, 8'h00, 1, 0, 6'h00));
    check("post_abort_miss", 32'(miss_count), 32'd1);
    check("post_abort_hit", 32'(hit_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
